// File: rtl/bti_sram_pkg.sv
// bti_sram_pkg: shared arbiter state, port id type and port count for bti_sram_arb
package bti_sram_pkg;
  localparam int NUM_PORTS = 2;
  typedef enum logic {IDLE, PEND} arb_state_e;
  typedef logic port_id_t;
endpackage

// File: rtl/bti_sram_if.sv
// bti_sram_if: bus_trans_if_t (req_vld/req_rdy/req_pkt{addr,wen,wdata}, rsp_vld/rsp_rdy/rsp_pkt{data}) and sram_if_t (addr/wen/wdata/rdata)
interface bus_trans_if_t #(parameter int AW = 32, parameter int DW = 32);
  logic req_vld;
  logic req_rdy;
  struct packed {logic [AW-1:0] addr; logic wen; logic [DW-1:0] wdata;} req_pkt;
  logic rsp_vld;
  logic rsp_rdy;
  struct packed {logic [DW-1:0] data;} rsp_pkt;
  modport master(output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
  modport slave(input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
endinterface

interface sram_if_t #(parameter int AW = 15, parameter int DW = 32);
  logic [AW-1:0] addr;
  logic wen;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  modport master(output addr, wen, wdata, input rdata);
  modport slave(input addr, wen, wdata, output rdata);
endinterface

// File: rtl/bti_rr_arb2.sv
// bti_rr_arb2: 2-input round-robin picker; ports clk, rst, req[1:0], advance -> gnt[1:0]; ptr names the port favoured on a tie
module bti_rr_arb2
  import bti_sram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] gnt
);
  port_id_t ptr;
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] | ptr);
  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (advance) ptr <= gnt[0];
  end
endmodule

// File: rtl/bti_sram_arb.sv
// bti_sram_arb: round-robin share of a 1-cycle-latency SRAM between bti0/bti1 (bus_trans_if_t.slave) onto sram_rw (sram_if_t.master), clk/rst sync active-high; BTI_SRAM_ARB_PERF_EN adds perf_gnt0/perf_gnt1/perf_stall
module bti_sram_arb
  import bti_sram_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SRAM_AW = 15
) (
  input  logic        clk,
  input  logic        rst,
  bus_trans_if_t.slave bti0,
  bus_trans_if_t.slave bti1,
  sram_if_t.master    sram_rw
`ifdef BTI_SRAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_stall
`endif
);
  arb_state_e st, st_nxt;
  port_id_t pend_port, gport;
  logic [SRAM_AW-1:0] pend_addr;
  logic [NUM_PORTS-1:0] req, gnt;
  logic rsp_hs, accept, hs, g_wen;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic unused_addr;
  assign req = {bti1.req_vld, bti0.req_vld};
  assign gport = gnt[1];
  assign rsp_hs = (st == PEND) & (pend_port ? bti1.rsp_rdy : bti0.rsp_rdy);
  assign accept = ~rst & ((st == IDLE) | rsp_hs);
  assign hs = accept & |req;
  assign unused_addr = ^{bti0.req_pkt.addr, bti1.req_pkt.addr};
  bti_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(hs),
    .gnt    (gnt)
  );
  always_comb begin
    g_addr = gport ? bti1.req_pkt.addr : bti0.req_pkt.addr;
    g_wen = gport ? bti1.req_pkt.wen : bti0.req_pkt.wen;
    g_wdata = gport ? bti1.req_pkt.wdata : bti0.req_pkt.wdata;
    st_nxt = hs ? PEND : rsp_hs ? IDLE : st;
    bti0.req_rdy = accept & gnt[0];
    bti1.req_rdy = accept & gnt[1];
    bti0.rsp_vld = (st == PEND) & ~pend_port;
    bti1.rsp_vld = (st == PEND) & pend_port;
    bti0.rsp_pkt.data = sram_rw.rdata;
    bti1.rsp_pkt.data = sram_rw.rdata;
    // while pending, keep re-reading the captured word so rdata stays stable under a stalled response
    sram_rw.addr = hs ? g_addr[SRAM_AW+1:2] : pend_addr;
    sram_rw.wen = hs & g_wen;
    sram_rw.wdata = g_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      pend_port <= 1'b0;
      pend_addr <= '0;
    end else begin
      st <= st_nxt;
      if (hs) begin
        pend_port <= gport;
        pend_addr <= g_addr[SRAM_AW+1:2];
      end
    end
  end
`ifdef BTI_SRAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0 <= '0;
      perf_gnt1 <= '0;
      perf_stall <= '0;
    end else begin
      perf_gnt0 <= perf_gnt0 + 32'(hs & gnt[0]);
      perf_gnt1 <= perf_gnt1 + 32'(hs & gnt[1]);
      perf_stall <= perf_stall + 32'(|req & ~hs);
    end
  end
`endif
endmodule
